serial_word_deserializer: RTL and testbench

//  Downstream consumer of the edge-triggered data flop: takes its registered serial bit

---
 rtl/serial_word_deserializer.sv | 145 ++++++++++++++
 tb/tb_serial_word_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler (LSB first) with a one-entry valid/ready output slot
// and a sticky overrun flag. Define PARITY_CHECK_EN to consume and check an even-parity bit per word.
module serial_word_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             overrun_o,
    output logic             parity_err_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               perr_q, perr_d;
    logic               busy_q;
    logic               complete;
    logic [WIDTH-1:0]   done_word;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = 1'b0;
        complete  = 1'b0;
        done_word = shift_q;

        if (valid_q && word_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bit_valid_i && start_i) begin
                    shift_d = WIDTH'(bit_in_i);
                    count_d = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid_i) begin
                    if (start_i) begin
                        // Realignment mid-word: drop the partial word silently.
                        shift_d = WIDTH'(bit_in_i);
                        count_d = CNT_W'(1);
                    end else begin
                        shift_d = shift_q | (WIDTH'(bit_in_i) << count_q);
                        if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                            count_d = CNT_W'(WIDTH);
                            state_d = PAR;
`else
                            complete  = 1'b1;
                            done_word = shift_d;
                            count_d   = '0;
                            state_d   = IDLE;
`endif
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PAR: begin
                if (bit_valid_i) begin
                    complete  = 1'b1;
                    done_word = shift_q;
                    perr_d    = (^shift_q) ^ bit_in_i;
                    count_d   = '0;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // A word may load when the slot is empty or is being drained this same cycle.
        if (complete) begin
            if (!valid_q || word_ready_i) begin
                word_d  = done_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign word_out_o   = word_q;
    assign word_valid_o = valid_q;
    assign overrun_o    = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=8); parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_word_deserializer;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       bit_in_i;
    logic       bit_valid_i;
    logic       start_i;
    logic [7:0] word_out_o;
    logic       word_valid_o;
    logic       word_ready_i;
    logic       overrun_o;
    logic       parity_err_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    serial_word_deserializer #(.WIDTH(8)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .bit_in_i     (bit_in_i),
        .bit_valid_i  (bit_valid_i),
        .start_i      (start_i),
        .word_out_o   (word_out_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        bit_in_i    = b;
        bit_valid_i = 1'b1;
        start_i     = s;
        @(posedge clock_i);
        #1;
        bit_valid_i = 1'b0;
        start_i     = 1'b0;
        bit_in_i    = 1'b0;
    endtask

    // Sends a full word (plus even parity when enabled); ready_last raises
    // word_ready for the final bit so completion and drain coincide.
    task automatic send_word(input logic [7:0] w, input int gap, input logic ready_last);
        for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
            if (i == 7 && ready_last) word_ready_i = 1'b1;
`endif
            send_bit(w[i], i == 0);
            if (gap > 0 && i < 7) idle(gap);
        end
`ifdef PARITY_CHECK_EN
        if (ready_last) word_ready_i = 1'b1;
        send_bit(^w, 1'b0);
`endif
    endtask

    task automatic drain(input string tag);
        word_ready_i = 1'b1;
        idle(1);
        chk(tag, 32'(word_valid_o), 32'd0);
        word_ready_i = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5           = 8'hA5;
        reset_i      = 1'b1;
        bit_in_i     = 1'b0;
        bit_valid_i  = 1'b0;
        start_i      = 1'b0;
        word_ready_i = 1'b0;
        idle(2);
        reset_i = 1'b0;

        chk("rst_valid",   32'(word_valid_o), 32'd0);
        chk("rst_word",    32'(word_out_o),   32'd0);
        chk("rst_overrun", 32'(overrun_o),    32'd0);
        chk("rst_busy",    32'(busy_o),       32'd0);
        chk("rst_perr",    32'(parity_err_o), 32'd0);

        // Basic word, plus the last-bit boundary: 7 bits in, nothing yet.
        for (int i = 0; i < 7; i++) send_bit(a5[i], i == 0);
        chk("bnd_valid_7bits", 32'(word_valid_o), 32'd0);
        chk("bnd_busy_7bits",  32'(busy_o),       32'd1);
        send_bit(a5[7], 1'b0);
`ifdef PARITY_CHECK_EN
        chk("bnd_par_wait", 32'(word_valid_o), 32'd0);
        send_bit(1'b0, 1'b0);
`endif
        chk("basic_valid", 32'(word_valid_o), 32'd1);
        chk("basic_word",  32'(word_out_o),   32'hA5);
        chk("basic_busy",  32'(busy_o),       32'd0);
        drain("basic_drain");

        // Stray bits without start are ignored; gaps between bits hold.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("stray_busy", 32'(busy_o), 32'd0);
        send_word(8'hA5, 2, 1'b0);
        chk("gap_valid", 32'(word_valid_o), 32'd1);
        chk("gap_word",  32'(word_out_o),   32'hA5);
        drain("gap_drain");

        // Start mid-word realigns.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(8'hA5, 0, 1'b0);
        chk("align_word",    32'(word_out_o), 32'hA5);
        chk("align_overrun", 32'(overrun_o),  32'd0);

        // Reset mid-word with a full slot clears everything.
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("mid_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        idle(2);
        reset_i = 1'b0;
        chk("mrst_valid", 32'(word_valid_o), 32'd0);
        chk("mrst_word",  32'(word_out_o),   32'd0);
        chk("mrst_busy",  32'(busy_o),       32'd0);
        // A continuation bit without start must not resume the dropped word.
        send_bit(1'b1, 1'b0);
        chk("mrst_idle", 32'(busy_o), 32'd0);

        // Overrun: second word dropped, first held, flag sticky.
        send_word(8'h3C, 0, 1'b0);
        chk("ovr_first", 32'(word_out_o), 32'h3C);
        send_word(8'hC3, 0, 1'b0);
        chk("ovr_word",  32'(word_out_o),   32'h3C);
        chk("ovr_valid", 32'(word_valid_o), 32'd1);
        chk("ovr_flag",  32'(overrun_o),    32'd1);
        idle(3);
        chk("ovr_hold_word", 32'(word_out_o), 32'h3C);
        drain("ovr_drain");
        chk("ovr_sticky", 32'(overrun_o), 32'd1);

        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        chk("ovr_clr", 32'(overrun_o), 32'd0);

        // Back-to-back: drain and load on the same edge.
        send_word(8'h11, 0, 1'b0);
        chk("b2b_first", 32'(word_out_o), 32'h11);
        send_word(8'h22, 0, 1'b1);
        chk("b2b_valid",   32'(word_valid_o), 32'd1);
        chk("b2b_word",    32'(word_out_o),   32'h22);
        chk("b2b_overrun", 32'(overrun_o),    32'd0);
        idle(1);
        chk("b2b_drop", 32'(word_valid_o), 32'd0);
        word_ready_i = 1'b0;

`ifdef PARITY_CHECK_EN
        for (int i = 0; i < 8; i++) send_bit(a5[i], i == 0);
        send_bit(1'b0, 1'b0);
        chk("par_ok_perr", 32'(parity_err_o), 32'd0);
        chk("par_ok_word", 32'(word_out_o),   32'hA5);
        drain("par_ok_drain");
        for (int i = 0; i < 8; i++) send_bit(a5[i], i == 0);
        send_bit(1'b1, 1'b0);
        chk("par_bad_perr", 32'(parity_err_o), 32'd1);
        chk("par_bad_word", 32'(word_out_o),   32'hA5);
        idle(1);
        chk("par_bad_pulse", 32'(parity_err_o), 32'd0);
`else
        chk("par_off", 32'(parity_err_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
